// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/subtract path: field widths,
// flag bit positions, the canonical quiet NaN and the sequencer states.
package fpu_pkg;

   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } fpu_state_t;

   function automatic int exp_w(input int bitness);
      case (bitness)
         16:      return 5;
         64:      return 11;
         default: return 8;
      endcase
   endfunction

   function automatic int mant_w(input int bitness);
      return bitness - 1 - exp_w(bitness);
   endfunction

   function automatic int bias(input int bitness);
      return (1 << (exp_w(bitness) - 1)) - 1;
   endfunction

   // Sign 0, exponent all ones, fraction MSB set, remaining fraction bits clear.
   function automatic logic [63:0] canonical_qnan(input int bitness);
      logic [63:0] v;
      v = '0;
      for (int i = mant_w(bitness) - 1; i <= bitness - 2; i++) begin
         v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fpu_lzc #(
   parameter int W = 27
) (
   input  logic [W-1:0]             value,
   output logic [$clog2(W+1)-1:0]   count
);

   localparam int CW = $clog2(W + 1);

   // Scanning upward lets the highest set bit have the final word.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (value[i]) begin
            count = CW'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor with round-to-nearest-even,
// subnormal support, signed zeros, special-case handling and exception flags.
module fpu_addsub
   import fpu_pkg::*;
#(
   parameter int bitness = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               input_rdy,
   output logic               input_ack,
   input  logic [bitness-1:0] data_a,
   input  logic [bitness-1:0] data_b,
   input  logic               op_sub,
   output logic               output_rdy,
   input  logic               output_ack,
   output logic [bitness-1:0] result,
   output logic [3:0]         flags
);

   localparam int EW  = exp_w(bitness);
   localparam int MW  = mant_w(bitness);
   localparam int SW  = MW + 1;
   localparam int XW  = MW + 4;
   localparam int XEW = EW + 2;
   localparam int CW  = $clog2(XW + 1);
   localparam logic [63:0]        QNAN_FULL = canonical_qnan(bitness);
   localparam logic [bitness-1:0] QNAN      = QNAN_FULL[bitness-1:0];
   localparam logic [XEW-1:0]     EXP_MAX   = XEW'((1 << EW) - 1);
   localparam logic [XEW-1:0]     SHIFT_SAT = XEW'(MW + 3);

   if (bitness != 16 && bitness != 32 && bitness != 64) begin : g_bad_bitness
      $error("fpu_addsub: bitness must be 16, 32 or 64");
   end

   fpu_state_t state, state_next;

   logic [bitness-1:0] opa, opb;
   logic               sub_q;
   logic               sign_a, sign_b;
   logic [XEW-1:0]     exp_a, exp_b;
   logic [SW-1:0]      sig_a, sig_b;
   logic               big_sign, eff_sub;
   logic [XEW-1:0]     big_exp;
   logic [XW-1:0]      big_ext, small_ext;
   logic [XW:0]        sum;
   logic               sum_sign;
   logic [XEW-1:0]     sum_exp;
   logic [XW-1:0]      norm_sig;
   logic [XEW-1:0]     norm_exp;
   logic               norm_sign;

   logic [EW-1:0] ea_raw, eb_raw;
   logic [MW-1:0] fa_raw, fb_raw;
   logic          sb_eff;
   logic          a_nan, b_nan, a_inf, b_inf;
   logic          special;
   logic [bitness-1:0] spec_result;
   logic [3:0]         spec_flags;

   assign ea_raw = opa[bitness-2:MW];
   assign eb_raw = opb[bitness-2:MW];
   assign fa_raw = opa[MW-1:0];
   assign fb_raw = opb[MW-1:0];
   assign sb_eff = opb[bitness-1] ^ sub_q;
   assign a_nan  = (&ea_raw) && (|fa_raw);
   assign b_nan  = (&eb_raw) && (|fb_raw);
   assign a_inf  = (&ea_raw) && !(|fa_raw);
   assign b_inf  = (&eb_raw) && !(|fb_raw);

   // Special operands bypass the arithmetic pipeline entirely.
   always_comb begin
      special     = 1'b0;
      spec_result = '0;
      spec_flags  = '0;
      if (a_nan || b_nan) begin
         special                  = 1'b1;
         spec_result              = QNAN;
         spec_flags[FLAG_INVALID] = (a_nan && !fa_raw[MW-1]) || (b_nan && !fb_raw[MW-1]);
      end else if (a_inf && b_inf && (opa[bitness-1] != sb_eff)) begin
         special                  = 1'b1;
         spec_result              = QNAN;
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
         special     = 1'b1;
         spec_result = {opa[bitness-1], {EW{1'b1}}, {MW{1'b0}}};
      end else if (b_inf) begin
         special     = 1'b1;
         spec_result = {sb_eff, {EW{1'b1}}, {MW{1'b0}}};
      end
   end

   logic           a_bigger;
   logic [XEW-1:0] exp_diff, shift_r;
   logic [XW-1:0]  small_raw, small_shifted;
   logic           small_lost;

   always_comb begin
      a_bigger      = {exp_a, sig_a} >= {exp_b, sig_b};
      exp_diff      = a_bigger ? (exp_a - exp_b) : (exp_b - exp_a);
      shift_r       = (exp_diff > SHIFT_SAT) ? SHIFT_SAT : exp_diff;
      small_raw     = {(a_bigger ? sig_b : sig_a), 3'b000};
      small_shifted = small_raw >> shift_r;
      small_lost    = |(small_raw & ~({XW{1'b1}} << shift_r));
   end

   logic [XW:0] sum_calc;
   assign sum_calc = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                             : ({1'b0, big_ext} + {1'b0, small_ext});

   logic [CW-1:0]  lz;
   logic [XEW-1:0] lz_ext, max_shift, shift_l;

   fpu_lzc #(.W(XW)) u_lzc (
      .value (sum[XW-1:0]),
      .count (lz)
   );

   // Normalising left shift stops at exponent 1 so tiny results become subnormal.
   always_comb begin
      lz_ext    = XEW'(lz);
      max_shift = sum_exp - XEW'(1);
      shift_l   = (lz_ext > max_shift) ? max_shift : lz_ext;
   end

   logic               round_up;
   logic [SW:0]        rounded;
   logic [SW-1:0]      fin_mant;
   logic [XEW-1:0]     fin_exp;
   logic               inexact;
   logic [bitness-1:0] round_result;
   logic [3:0]         round_flags;

   always_comb begin
      round_up    = norm_sig[2] & (norm_sig[1] | norm_sig[0] | norm_sig[3]);
      rounded     = {1'b0, norm_sig[XW-1:3]} + {{SW{1'b0}}, round_up};
      inexact     = |norm_sig[2:0];
      round_flags = '0;
      round_flags[FLAG_INEXACT] = inexact;
      if (rounded[SW]) begin
         fin_mant = rounded[SW:1];
         fin_exp  = norm_exp + XEW'(1);
      end else begin
         fin_mant = rounded[SW-1:0];
         fin_exp  = norm_exp;
      end
      if (fin_exp >= EXP_MAX) begin
         round_result               = {norm_sign, {EW{1'b1}}, {MW{1'b0}}};
         round_flags[FLAG_OVERFLOW] = 1'b1;
         round_flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         round_result = {norm_sign, (fin_mant[SW-1] ? fin_exp[EW-1:0] : {EW{1'b0}}), fin_mant[MW-1:0]};
         round_flags[FLAG_UNDERFLOW] = !fin_mant[SW-1] && inexact;
      end
   end

   always_comb begin
      state_next = state;
      input_ack  = 1'b0;
      output_rdy = 1'b0;
      case (state)
         S_IDLE:   if (input_rdy) state_next = S_UNPACK;
         S_UNPACK: begin
            input_ack  = 1'b1;
            state_next = special ? S_DONE : S_ALIGN;
         end
         S_ALIGN:  state_next = S_ADD;
         S_ADD:    state_next = S_NORM;
         S_NORM:   state_next = S_ROUND;
         S_ROUND:  state_next = S_DONE;
         S_DONE: begin
            output_rdy = 1'b1;
            if (output_ack) state_next = S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= S_IDLE;
         result <= '0;
         flags  <= '0;
      end else begin
         state <= state_next;
         if (state == S_UNPACK && special) begin
            result <= spec_result;
            flags  <= spec_flags;
         end else if (state == S_ROUND) begin
            result <= round_result;
            flags  <= round_flags;
         end
      end
   end

   // Datapath stage registers; an aborted operation simply leaves stale values behind.
   always_ff @(posedge clock) begin
      case (state)
         S_IDLE: if (input_rdy) begin
            opa   <= data_a;
            opb   <= data_b;
            sub_q <= op_sub;
         end
         S_UNPACK: begin
            sign_a <= opa[bitness-1];
            sign_b <= sb_eff;
            exp_a  <= (ea_raw == '0) ? XEW'(1) : XEW'(ea_raw);
            exp_b  <= (eb_raw == '0) ? XEW'(1) : XEW'(eb_raw);
            sig_a  <= {(ea_raw != '0), fa_raw};
            sig_b  <= {(eb_raw != '0), fb_raw};
         end
         S_ALIGN: begin
            big_sign  <= a_bigger ? sign_a : sign_b;
            eff_sub   <= sign_a ^ sign_b;
            big_exp   <= a_bigger ? exp_a : exp_b;
            big_ext   <= {(a_bigger ? sig_a : sig_b), 3'b000};
            small_ext <= {small_shifted[XW-1:1], small_shifted[0] | small_lost};
         end
         S_ADD: begin
            sum      <= sum_calc;
            sum_exp  <= big_exp;
            sum_sign <= (sum_calc == '0) ? (!eff_sub && big_sign) : big_sign;
         end
         S_NORM: begin
            norm_sign <= sum_sign;
            if (sum[XW]) begin
               norm_sig <= {sum[XW:2], sum[1] | sum[0]};
               norm_exp <= sum_exp + XEW'(1);
            end else begin
               norm_sig <= sum[XW-1:0] << shift_l;
               norm_exp <= sum_exp - shift_l;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpu_addsub.sv
// Scoreboard bench for fpu_addsub: exact big-integer reference model for binary32,
// plus a few half-precision vectors on a second instance.
module tb_fpu_addsub;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        input_rdy = 1'b0;
   logic        input_ack;
   logic [31:0] data_a = '0;
   logic [31:0] data_b = '0;
   logic        op_sub = 1'b0;
   logic        output_rdy;
   logic        output_ack;
   logic [31:0] result;
   logic [3:0]  flags;

   logic        h_input_rdy = 1'b0;
   logic        h_input_ack;
   logic [15:0] h_data_a = '0;
   logic [15:0] h_data_b = '0;
   logic        h_op_sub = 1'b0;
   logic        h_output_rdy;
   logic        h_output_ack = 1'b0;
   logic [15:0] h_result;
   logic [3:0]  h_flags;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      int          cap;
      int          hold;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                 32'h7FC00000, 32'h7F800001, 32'hFFC12345, 32'h7F7FFFFF};

   localparam int NVEC = 14;
   vec_t vecs [NVEC] = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 5},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 5},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 5},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1},
      '{32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 4'b0000, 5},
      '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 5},
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1},
      '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1},
      '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 5},
      '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 5}
   };

   fpu_addsub #(.bitness(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .input_rdy  (input_rdy),
      .input_ack  (input_ack),
      .data_a     (data_a),
      .data_b     (data_b),
      .op_sub     (op_sub),
      .output_rdy (output_rdy),
      .output_ack (output_ack),
      .result     (result),
      .flags      (flags)
   );

   fpu_addsub #(.bitness(16)) dut16 (
      .clock      (clock),
      .reset      (reset),
      .input_rdy  (h_input_rdy),
      .input_ack  (h_input_ack),
      .data_a     (h_data_a),
      .data_b     (h_data_b),
      .op_sub     (h_op_sub),
      .output_rdy (h_output_rdy),
      .output_ack (h_output_ack),
      .result     (h_result),
      .flags      (h_flags)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Exact sum of both operands as an integer count of 2^-149, then one RNE rounding.
   function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                   output logic [31:0] res, output logic [3:0] fl, output int lat);
      logic         sa, sb, an, bn, ai, bi, sign, up;
      logic [7:0]   ea, eb;
      logic [22:0]  fa, fb;
      logic [287:0] ma, mb, mag, kept, rem, half;
      int           p, drop, e;
      sa = a[31]; sb = b[31] ^ sub;
      ea = a[30:23]; eb = b[30:23];
      fa = a[22:0];  fb = b[22:0];
      an = (ea == 8'hFF) && (fa != 0);
      bn = (eb == 8'hFF) && (fb != 0);
      ai = (ea == 8'hFF) && (fa == 0);
      bi = (eb == 8'hFF) && (fb == 0);
      fl = 4'b0000;
      lat = 1;
      if (an || bn) begin
         res = 32'h7FC00000;
         fl[3] = (an && !fa[22]) || (bn && !fb[22]);
         return;
      end
      if (ai && bi) begin
         if (sa != sb) begin res = 32'h7FC00000; fl = 4'b1000; end
         else res = {sa, 8'hFF, 23'h0};
         return;
      end
      if (ai) begin res = {sa, 8'hFF, 23'h0}; return; end
      if (bi) begin res = {sb, 8'hFF, 23'h0}; return; end
      lat = 5;
      ma = 288'({(ea != 0), fa});
      mb = 288'({(eb != 0), fb});
      if (ea != 0) ma = ma << (ea - 1);
      if (eb != 0) mb = mb << (eb - 1);
      if (sa == sb) begin
         mag = ma + mb; sign = sa;
      end else if (ma >= mb) begin
         mag = ma - mb; sign = (ma == mb) ? 1'b0 : sa;
      end else begin
         mag = mb - ma; sign = sb;
      end
      if (mag == 0) begin
         res = {sign, 31'h0};
         return;
      end
      p = 0;
      for (int i = 0; i < 288; i++) if (mag[i]) p = i;
      if (p <= 23) begin
         res = {sign, mag[30:0]};
         return;
      end
      drop = p - 23;
      kept = mag >> drop;
      rem  = mag - (kept << drop);
      half = 288'(1) << (drop - 1);
      up   = (rem > half) || ((rem == half) && kept[0]);
      kept = kept + 288'(up);
      if (kept[24]) begin kept = kept >> 1; drop++; end
      fl[0] = (rem != 0);
      e = drop + 1;
      if (e >= 255) begin
         res = {sign, 8'hFF, 23'h0};
         fl  = 4'b0101;
      end else begin
         res = {sign, 8'(e), kept[22:0]};
      end
   endfunction

   function automatic logic [31:0] rand_operand(input int base_exp);
      logic [31:0] v;
      int          kind, e;
      v = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
         e = base_exp + int'($urandom_range(0, 30)) - 15;
         if (e < 1) e = 1;
         if (e > 254) e = 254;
         v[30:23] = 8'(e);
      end else if (kind == 6) begin
         v[30:23] = 8'h00;
      end else if (kind == 7) begin
         v = specials[$urandom_range(0, 7)];
      end
      return v;
   endfunction

   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input bit do_push, input logic [31:0] want_res,
                                 input logic [3:0] want_fl, input int want_lat, input int hold);
      bit got;
      @(negedge clock);
      data_a = a; data_b = b; op_sub = sub; input_rdy = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clock);
         #1;
         got = input_ack;
      end
      input_rdy = 1'b0;
      check_value("input_ack", 64'(got), 64'(1));
      if (got && do_push) exp_q.push_back('{want_res, want_fl, want_lat, cycle, hold});
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || output_rdy === 1'b1 || output_ack === 1'b1) && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_value("drain_in_time", 64'(n < 500), 64'(1));
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] want_r, input logic [3:0] want_f);
      bit got;
      @(negedge clock);
      h_data_a = a; h_data_b = b; h_op_sub = sub; h_input_rdy = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clock);
         #1;
         got = h_input_ack;
      end
      h_input_rdy = 1'b0;
      check_value("h_input_ack", 64'(got), 64'(1));
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clock);
         got = h_output_rdy;
      end
      check_value("h_output_rdy", 64'(got), 64'(1));
      check_value("h_result", 64'(h_result), 64'(want_r));
      check_value("h_flags", 64'(h_flags), 64'(want_f));
      h_output_ack = 1'b1;
      @(negedge clock);
      h_output_ack = 1'b0;
   endtask

   // Monitor: pops the oldest expectation whenever a result is presented.
   initial begin : monitor
      exp_t e;
      output_ack = 1'b0;
      forever begin
         @(negedge clock);
         if (output_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output got=%0h want=none", result);
            end else begin
               e = exp_q.pop_front();
               check_value("result", 64'(result), 64'(e.res));
               check_value("flags", 64'(flags), 64'(e.fl));
               check_value("latency", 64'(cycle - e.cap), 64'(e.lat));
               for (int h = 0; h < e.hold; h++) begin
                  @(negedge clock);
                  check_value("hold_rdy", 64'(output_rdy), 64'(1));
                  check_value("hold_result", 64'(result), 64'(e.res));
               end
            end
            output_ack = 1'b1;
            @(negedge clock);
            output_ack = 1'b0;
         end
      end
   end

   initial begin : stimulus
      logic [31:0] a, b, r;
      logic [3:0]  f;
      logic        sub;
      int          lat, base, seen;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_value("reset_output_rdy", 64'(output_rdy), 64'(0));
      check_value("reset_input_ack", 64'(input_ack), 64'(0));
      check_value("reset_result", 64'(result), 64'(0));
      check_value("reset_flags", 64'(flags), 64'(0));
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].res,
                        vecs[i].fl, vecs[i].lat, (i == 0) ? 10 : 0);
      end
      wait_drain();

      // Operand request raised while the datapath is busy in ALIGN must be ignored.
      apply_stimulus(32'h3F800000, 32'h40400000, 1'b0, 1'b1, 32'h40800000, 4'b0000, 5, 0);
      @(posedge clock);
      #1;
      data_a = 32'h12345678; data_b = 32'h01234567; input_rdy = 1'b1;
      @(posedge clock);
      #1;
      check_value("ack_during_align", 64'(input_ack), 64'(0));
      input_rdy = 1'b0;
      @(posedge clock);
      #1;
      check_value("ack_after_align", 64'(input_ack), 64'(0));
      wait_drain();

      // Abort an operation in ADD with reset and confirm it leaves no trace.
      apply_stimulus(32'h40A00000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 4'b0000, 5, 0);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      check_value("abort_result", 64'(result), 64'(0));
      check_value("abort_flags", 64'(flags), 64'(0));
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (output_rdy === 1'b1 || input_ack === 1'b1) seen++;
      end
      check_value("abort_quiet", 64'(seen), 64'(0));
      apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 4'b0000, 5, 0);
      wait_drain();

      for (int i = 0; i < 300; i++) begin
         base = $urandom_range(1, 254);
         a = rand_operand(base);
         b = ($urandom_range(0, 7) == 0) ? a : rand_operand(base);
         sub = 1'($urandom_range(0, 1));
         ref_add(a, b, sub, r, f, lat);
         apply_stimulus(a, b, sub, 1'b1, r, f, lat, $urandom_range(0, 2));
      end
      wait_drain();

      run16(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
      run16(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
      run16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);

      check_value("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
